dmem_arbiter: RTL

Two-port arbiter that shares the single-ported data memory (DMem) between the CPU load/store port and a debug/loader port. It grants at most one access per cycle and drives DMem's write-enable, address, write-data and pc inputs. It captures DMem's combinational read data into a registered response one cycle after the grant. It sits between the core's memory stage, the debug/loader master, and DMem.

---
 rtl/dmem_arb_pkg.sv | 37 +++
 rtl/dmem_arb_resp.sv | 24 ++
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the DMem arbiter. Widths default from the ADDR_SIZE / WORD_LEN defines.
// Build option: define DMEM_ARB_RR_EN for round-robin conflict resolution.
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

package dmem_arb_pkg;

    localparam int ADDR_W_DEF   = `ADDR_SIZE;
    localparam int DATA_W_DEF   = `WORD_LEN;
    localparam int LOCK_MAX_DEF = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CPU,
        S_DBG,
        S_DBG_LOCK
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_DBG
    } owner_e;

    function automatic owner_e owner_of(arb_state_e s);
        case (s)
            S_CPU:             return OWN_CPU;
            S_DBG, S_DBG_LOCK: return OWN_DBG;
            default:           return OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/dmem_arb_resp.sv
// Per-port response stage: rvalid one cycle after a grant, rdata captured at the grant edge.
module dmem_arb_resp #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              gnt,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= gnt;
            if (gnt)
                rdata <= mem_rdata;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-ported DMem between the CPU and debug ports; at most one grant per cycle.
// Define DMEM_ARB_RR_EN for round-robin conflicts, otherwise the CPU always wins.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [ADDR_W-1:0] cpu_pc,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] mem_pc,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

    arb_state_e        state;
    logic [CNT_W-1:0]  lock_cnt;
    logic              lock_blk;
    logic [ADDR_W-1:0] addr_q, pc_q;
    logic [DATA_W-1:0] wdata_q;
    logic              expired, locked, cpu_win, enter_lock;

    // The entry grant is the first locked grant, so the counter starts at 1 and
    // the lock expires once LOCK_MAX debug grants have been issued.
    always_comb begin
        expired    = (state == S_DBG_LOCK) && (lock_cnt == CNT_MAX);
        locked     = (state == S_DBG_LOCK) && dbg_lock && !expired;
`ifdef DMEM_ARB_RR_EN
        cpu_win    = cpu_req && (!dbg_req || owner_of(state) != OWN_CPU);
`else
        cpu_win    = cpu_req;
`endif
        cpu_gnt    = 1'b0;
        dbg_gnt    = 1'b0;
        if (!rst) begin
            if (locked) begin
                dbg_gnt = dbg_req;
            end else begin
                cpu_gnt = cpu_win;
                dbg_gnt = dbg_req && !cpu_win;
            end
        end
        enter_lock = dbg_gnt && !locked && dbg_lock && !lock_blk && !expired;
    end

    assign mem_we    = (cpu_gnt & cpu_we) | (dbg_gnt & dbg_we);
    assign mem_addr  = cpu_gnt ? cpu_addr  : (dbg_gnt ? dbg_addr  : addr_q);
    assign mem_wdata = cpu_gnt ? cpu_wdata : (dbg_gnt ? dbg_wdata : wdata_q);
    assign mem_pc    = cpu_gnt ? cpu_pc    : (dbg_gnt ? '0        : pc_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            lock_cnt <= '0;
            lock_blk <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            pc_q     <= '0;
        end else begin
            // After an expiry the debug port must drop dbg_lock before it can relock.
            lock_blk <= dbg_lock && (lock_blk || expired);
            if (cpu_gnt || dbg_gnt) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
                pc_q    <= mem_pc;
            end
            if (cpu_gnt) begin
                state <= S_CPU;
            end else if (dbg_gnt) begin
                if (locked) begin
                    if (lock_cnt != CNT_MAX)
                        lock_cnt <= lock_cnt + 1'b1;
                end else if (enter_lock) begin
                    state    <= S_DBG_LOCK;
                    lock_cnt <= CNT_W'(1);
                end else begin
                    state <= S_DBG;
                end
            end else if (state == S_DBG_LOCK && !locked) begin
                state <= S_DBG;
            end
        end
    end

    dmem_arb_resp #(.DATA_W(DATA_W)) u_cpu_resp (
        .clk       (clk),
        .rst       (rst),
        .gnt       (cpu_gnt),
        .mem_rdata (mem_rdata),
        .rvalid    (cpu_rvalid),
        .rdata     (cpu_rdata)
    );

    dmem_arb_resp #(.DATA_W(DATA_W)) u_dbg_resp (
        .clk       (clk),
        .rst       (rst),
        .gnt       (dbg_gnt),
        .mem_rdata (mem_rdata),
        .rvalid    (dbg_rvalid),
        .rdata     (dbg_rdata)
    );

endmodule
